boid_frame_writer: RTL

BOID_FRAME_WRITER -- requirements
Module: boid_frame_writer

---
 rtl/boid_pkg.sv | 21 ++
 rtl/boid_frame_writer_pixel_addr.sv | 42 ++++
 rtl/boid_frame_writer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/boid_pkg.sv
// rtl/boid_pkg.sv - shared display geometry, coordinate widths and FSM encoding for the boid frame writer
// Contents:
//   H_RES, V_RES   default display resolution in pixels
//   ADDR_W         pixel address width, $clog2(H_RES*V_RES)
//   X_W, Y_W       width of one packed boid x / y coordinate
//   state_t        writer FSM states
package boid_pkg;

    localparam int H_RES  = 640;
    localparam int V_RES  = 480;
    localparam int ADDR_W = 19;
    localparam int X_W    = 10;
    localparam int Y_W    = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ERASE = 2'd1,
        ST_DRAW  = 2'd2
    } state_t;

endpackage

// File: rtl/boid_frame_writer_pixel_addr.sv
// rtl/boid_frame_writer_pixel_addr.sv - boid_pixel_addr: sprite pixel to linear address with screen clipping
// Ports:
//   x, y        boid sprite origin
//   dx, dy      offset inside the sprite (0..7)
//   addr        (y+dy)*H_RES + (x+dx), built from shifted adds of the constant H_RES
//   in_bounds   1 when the pixel lies on screen
module boid_pixel_addr #(
    parameter int H_RES  = boid_pkg::H_RES,
    parameter int V_RES  = boid_pkg::V_RES,
    parameter int ADDR_W = boid_pkg::ADDR_W
) (
    input  logic [boid_pkg::X_W-1:0] x,
    input  logic [boid_pkg::Y_W-1:0] y,
    input  logic [2:0]               dx,
    input  logic [2:0]               dy,
    output logic [ADDR_W-1:0]        addr,
    output logic                     in_bounds
);
    import boid_pkg::*;

    logic [10:0]       xx;
    logic [9:0]        yy;
    logic [ADDR_W-1:0] acc;

    assign xx = {1'b0, x} + {8'b0, dx};
    assign yy = {1'b0, y} + {7'b0, dy};

    // H_RES is a constant, so each set bit contributes one shifted copy of yy;
    // for 640 this collapses to (yy << 9) + (yy << 7).
    always_comb begin
        acc = ADDR_W'(xx);
        for (int i = 0; i < 32; i++) begin
            if (H_RES[i]) begin
                acc = acc + (ADDR_W'(yy) << i);
            end
        end
    end

    assign addr      = acc;
    assign in_bounds = ({21'b0, xx} < 32'(H_RES)) && ({22'b0, yy} < 32'(V_RES));

endmodule

// File: rtl/boid_frame_writer.sv
// rtl/boid_frame_writer.sv - double-buffered boid sprite writer: erase old sprites, then draw new ones
// Ports:
//   clock, reset          system clock, asynchronous active-high reset
//   frame_start           end-of-frame pulse; starts a new erase/draw pass when idle
//   boid_x/boid_y/valid   packed boid positions and draw enables, sampled on frame_start
//   overrun_clr           clears the sticky overrun flag
//   wr_en/wr_addr/wr_data registered display-RAM write port (data 0 erase, 1 draw)
//   wr_buf, disp_buf      back buffer being written / front buffer being displayed
//   busy                  high during ERASE and DRAW
//   overrun               set when a frame_start arrives while busy
module boid_frame_writer #(
    parameter int NUM_BOIDS = 4,
    parameter int BOID_SIZE = 2,
    parameter int H_RES     = 640,
    parameter int V_RES     = 480,
    parameter int ADDR_W    = 19
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               frame_start,
    input  logic [NUM_BOIDS*boid_pkg::X_W-1:0] boid_x,
    input  logic [NUM_BOIDS*boid_pkg::Y_W-1:0] boid_y,
    input  logic [NUM_BOIDS-1:0]               boid_valid,
    input  logic                               overrun_clr,
    output logic                               wr_en,
    output logic [ADDR_W-1:0]                  wr_addr,
    output logic                               wr_data,
    output logic                               wr_buf,
    output logic                               disp_buf,
    output logic                               busy,
    output logic                               overrun
);
    import boid_pkg::*;

    localparam int                BIDX_W = (NUM_BOIDS > 1) ? $clog2(NUM_BOIDS) : 1;
    localparam logic [2:0]        LAST_D = 3'(BOID_SIZE - 1);
    localparam logic [BIDX_W-1:0] LAST_B = BIDX_W'(NUM_BOIDS - 1);

    state_t            state, nxt_state;
    logic [BIDX_W-1:0] boid, nxt_boid;
    logic [2:0]        dy, dx, nxt_dy, nxt_dx;

    // One snapshot per display buffer, plus the erase copy that receives the
    // outgoing snapshot of the back buffer when a new one overwrites it.
    logic [X_W-1:0] snap_x [2][NUM_BOIDS];
    logic [Y_W-1:0] snap_y [2][NUM_BOIDS];
    logic           snap_v [2][NUM_BOIDS];
    logic [X_W-1:0] ers_x  [NUM_BOIDS];
    logic [Y_W-1:0] ers_y  [NUM_BOIDS];
    logic           ers_v  [NUM_BOIDS];

    logic [X_W-1:0]    src_x;
    logic [Y_W-1:0]    src_y;
    logic              src_v;
    logic [ADDR_W-1:0] pix_addr;
    logic              pix_in;

    assign wr_buf = ~disp_buf;
    assign busy   = (state != ST_IDLE);

    always_comb begin
        nxt_state = state;
        nxt_boid  = boid;
        nxt_dy    = dy;
        nxt_dx    = dx;
        case (state)
            ST_IDLE: if (frame_start) nxt_state = ST_ERASE;
            ST_ERASE, ST_DRAW: begin
                if (dx != LAST_D) begin
                    nxt_dx = dx + 3'd1;
                end else begin
                    nxt_dx = 3'd0;
                    if (dy != LAST_D) begin
                        nxt_dy = dy + 3'd1;
                    end else begin
                        nxt_dy = 3'd0;
                        if (boid != LAST_B) begin
                            nxt_boid = boid + 1'b1;
                        end else begin
                            nxt_boid  = '0;
                            nxt_state = (state == ST_ERASE) ? ST_DRAW : ST_IDLE;
                        end
                    end
                end
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    // The write port is registered from the upcoming visit, so wr_en lines up
    // with busy. On the start edge the erase copy is not loaded yet; the
    // outgoing snapshot still sits in snap[disp_buf] (the next back buffer).
    always_comb begin
        src_x = snap_x[wr_buf][nxt_boid];
        src_y = snap_y[wr_buf][nxt_boid];
        src_v = snap_v[wr_buf][nxt_boid];
        if (nxt_state == ST_ERASE) begin
            if (state == ST_IDLE) begin
                src_x = snap_x[disp_buf][nxt_boid];
                src_y = snap_y[disp_buf][nxt_boid];
                src_v = snap_v[disp_buf][nxt_boid];
            end else begin
                src_x = ers_x[nxt_boid];
                src_y = ers_y[nxt_boid];
                src_v = ers_v[nxt_boid];
            end
        end
    end

    boid_pixel_addr #(
        .H_RES (H_RES),
        .V_RES (V_RES),
        .ADDR_W(ADDR_W)
    ) u_pixel_addr (
        .x        (src_x),
        .y        (src_y),
        .dx       (nxt_dx),
        .dy       (nxt_dy),
        .addr     (pix_addr),
        .in_bounds(pix_in)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            boid     <= '0;
            dy       <= 3'd0;
            dx       <= 3'd0;
            disp_buf <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= 1'b0;
            overrun  <= 1'b0;
            for (int i = 0; i < NUM_BOIDS; i++) begin
                for (int b = 0; b < 2; b++) begin
                    snap_x[b][i] <= '0;
                    snap_y[b][i] <= '0;
                    snap_v[b][i] <= 1'b0;
                end
                ers_x[i] <= '0;
                ers_y[i] <= '0;
                ers_v[i] <= 1'b0;
            end
        end else begin
            state   <= nxt_state;
            boid    <= nxt_boid;
            dy      <= nxt_dy;
            dx      <= nxt_dx;
            wr_en   <= (nxt_state != ST_IDLE) && src_v && pix_in;
            if (nxt_state != ST_IDLE) begin
                wr_addr <= pix_addr;
                wr_data <= (nxt_state == ST_DRAW);
            end
            overrun <= (overrun && !overrun_clr) || (frame_start && state != ST_IDLE);
            if (frame_start && state == ST_IDLE) begin
                disp_buf <= ~disp_buf;
                for (int i = 0; i < NUM_BOIDS; i++) begin
                    ers_x[i]            <= snap_x[disp_buf][i];
                    ers_y[i]            <= snap_y[disp_buf][i];
                    ers_v[i]            <= snap_v[disp_buf][i];
                    snap_x[disp_buf][i] <= boid_x[X_W*i +: X_W];
                    snap_y[disp_buf][i] <= boid_y[Y_W*i +: Y_W];
                    snap_v[disp_buf][i] <= boid_valid[i];
                end
            end
        end
    end

endmodule
